// File: rtl/pcie_tx_arb.sv
// Two-requester posted-write arbiter in front of the PCIe core TX VC0 port.
// Round-robin with credit gating, grant handshake and an XFER watchdog.
module pcie_tx_arb #(
  parameter int unsigned TMO_CYC = 1024
) (
  input  logic        clk_125,
  input  logic        rstn,
  input  logic        req0,
  input  logic        req1,
  input  logic [9:0]  len0,
  input  logic [9:0]  len1,
  output logic        gnt0,
  output logic        gnt1,
  input  logic        st0,
  input  logic        st1,
  input  logic        end0,
  input  logic        end1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic        tx_req,
  input  logic        tx_rdy,
  output logic        tx_st,
  output logic        tx_end,
  output logic [15:0] tx_data,
  input  logic [8:0]  tx_ca_ph,
  input  logic [12:0] tx_ca_pd,
  input  logic        tx_ca_p_recheck,
  output logic        owner,
  output logic        busy,
  output logic        tmo_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        tx_req_q, tx_req_d;
  logic        tmo_q, tmo_d;
  logic [15:0] cnt_q, cnt_d;

  logic        gnt;
  logic        ph_ok;
  logic        elig0, elig1;
  logic [8:0]  need0, need1;
  logic        o_st, o_end;
  logic [15:0] o_data;

  // 0 DW encodes 1024 DW, i.e. 256 data credits
  function automatic logic [8:0] need_cr(input logic [9:0] len);
    logic [10:0] t;
    t = {1'b0, len} + 11'd3;
    return (len == 10'd0) ? 9'd256 : t[10:2];
  endfunction

  assign need0 = need_cr(len0);
  assign need1 = need_cr(len1);
  assign ph_ok = tx_ca_ph[8] | (tx_ca_ph[7:0] != 8'd0);

  assign elig0 = req0 & ph_ok &
    (tx_ca_pd[12] | (tx_ca_pd[11:0] >= {3'b000, need0}));
  assign elig1 = req1 & ph_ok &
    (tx_ca_pd[12] | (tx_ca_pd[11:0] >= {3'b000, need1}));

  assign o_st   = owner_q ? st1 : st0;
  assign o_end  = owner_q ? end1 : end0;
  assign o_data = owner_q ? data1 : data0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    tx_st   = 1'b0;
    tx_end  = 1'b0;
    tx_data = 16'd0;
    unique case (state_q)
      S_IDLE: begin
        if (elig0 | elig1) begin
          owner_d = (elig0 & elig1) ? ~owner_q : elig1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (tx_rdy) begin
          gnt     = 1'b1;
          cnt_d   = 16'd0;
          state_d = S_XFER;
        end else if (tx_ca_p_recheck) begin
          state_d = S_IDLE;
        end
      end
      S_XFER: begin
        tx_st   = o_st;
        tx_end  = o_end;
        tx_data = o_data;
        cnt_d   = cnt_q + 16'd1;
        if (o_end) begin
          state_d = S_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          tx_end  = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    tx_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b1;
      tx_req_q <= 1'b0;
      tmo_q    <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      tx_req_q <= tx_req_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt0    = gnt & ~owner_q;
  assign gnt1    = gnt & owner_q;
  assign tx_req  = tx_req_q;
  assign owner   = owner_q;
  assign busy    = (state_q != S_IDLE);
  assign tmo_err = tmo_q;

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Randomized scoreboard bench for pcie_tx_arb.
// Grants and per-cycle TX beats are predicted and checked by a monitor.
module tb_pcie_tx_arb;

  localparam int TMO = 16;

  logic        clk_125 = 1'b0;
  logic        rstn;
  logic        rq [2];
  logic [9:0]  ln [2];
  logic        st [2];
  logic        en [2];
  logic [15:0] dat [2];
  logic        gnt0, gnt1;
  logic        tx_req, tx_rdy;
  logic        tx_st, tx_end;
  logic [15:0] tx_data;
  logic [8:0]  ph;
  logic [12:0] pd;
  logic        recheck;
  logic        owner, busy, tmo_err;

  typedef struct {
    logic        st;
    logic        en;
    logic [15:0] d;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  int    exp_gnt[$];
  beat_t exp_beat[$];
  bit    mon_en = 0;
  int    last;

  always #4 clk_125 = ~clk_125;

  pcie_tx_arb #(.TMO_CYC(TMO)) dut (
    .clk_125(clk_125), .rstn(rstn),
    .req0(rq[0]), .req1(rq[1]),
    .len0(ln[0]), .len1(ln[1]),
    .gnt0(gnt0), .gnt1(gnt1),
    .st0(st[0]), .st1(st[1]),
    .end0(en[0]), .end1(en[1]),
    .data0(dat[0]), .data1(dat[1]),
    .tx_req(tx_req), .tx_rdy(tx_rdy),
    .tx_st(tx_st), .tx_end(tx_end), .tx_data(tx_data),
    .tx_ca_ph(ph), .tx_ca_pd(pd),
    .tx_ca_p_recheck(recheck),
    .owner(owner), .busy(busy), .tmo_err(tmo_err)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, act, exp);
    end
  endtask

  // Monitor: consumes predicted grants and XFER beats
  always @(negedge clk_125) begin
    beat_t b;
    if (mon_en) begin
      if (gnt0 | gnt1) begin
        chk("gnt_onehot", 32'(gnt0 & gnt1), 0);
        if (exp_gnt.size() == 0)
          chk("gnt_unexpected", 32'(exp_gnt.size()), 1);
        else
          chk("gnt_idx", 32'(gnt1), 32'(exp_gnt.pop_front()));
      end
      if (busy && !tx_req) begin
        if (exp_beat.size() == 0) begin
          chk("beat_unexpected", 32'(exp_beat.size()), 1);
        end else begin
          b = exp_beat.pop_front();
          chk("tx_st", 32'(tx_st), 32'(b.st));
          chk("tx_end", 32'(tx_end), 32'(b.en));
          chk("tx_data", 32'(tx_data), 32'(b.d));
        end
      end else begin
        chk("tx_quiet", {13'd0, tx_st, tx_end, tx_data}, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_125);
    #1;
  endtask

  function automatic int need(logic [9:0] l);
    return (l == 0) ? 256 : (int'(l) + 3) / 4;
  endfunction

  function automatic bit elig(int i);
    bit hok, dok;
    hok = ph[8] || (ph[7:0] >= 1);
    dok = pd[12] || (int'(pd[11:0]) >= need(ln[i]));
    return rq[i] && hok && dok;
  endfunction

  function automatic logic [9:0] pick_len();
    case ($urandom_range(0, 3))
      0: return 10'd0;
      1: return 10'($urandom_range(1, 16));
      2: return 10'($urandom_range(17, 1023));
      default: return 10'd64;
    endcase
  endfunction

  task automatic pick_credits();
    case ($urandom_range(0, 5))
      0: ph = 9'h000;
      1: ph = 9'h100 | 9'($urandom_range(0, 255));
      default: ph = 9'($urandom_range(1, 255));
    endcase
    case ($urandom_range(0, 4))
      0: pd = 13'h0000;
      1: pd = 13'h1000;
      2: pd = 13'd8;
      default: pd = 13'($urandom_range(1, 300));
    endcase
  endtask

  // Called in an IDLE cycle, 1ns after the clock edge
  task automatic round(bit allow_rc, bit add_new, bit inf);
    bit e0, e1;
    int w, n, o;
    beat_t b;
    if (add_new) begin
      for (int i = 0; i < 2; i++)
        if (!rq[i]) begin
          rq[i] = 1'($urandom_range(0, 1));
          ln[i] = pick_len();
        end
      if (!rq[0] && !rq[1]) begin
        w = $urandom_range(0, 1);
        rq[w] = 1'b1;
        ln[w] = pick_len();
      end
    end
    if (inf) begin
      ph = 9'h100;
      pd = 13'h1000;
    end else begin
      pick_credits();
    end
    e0 = elig(0);
    e1 = elig(1);
    if (!e0 && !e1) begin
      repeat (4) tick();
      chk("idle_no_elig", 32'(busy), 0);
      ph = 9'h100;
      pd = 13'h1000;
      e0 = elig(0);
      e1 = elig(1);
    end
    w = (e0 && e1) ? 1 - last : (e1 ? 1 : 0);
    last = w;
    tick();
    chk("tx_req_lat", 32'(tx_req), 1);
    chk("owner", 32'(owner), 32'(w));
    repeat ($urandom_range(0, 2)) tick();
    if (allow_rc && $urandom_range(0, 1) == 1) begin
      recheck = 1'b1;
      pd = 13'h0000;
      tick();
      recheck = 1'b0;
      chk("recheck_drop", 32'(tx_req), 0);
      repeat (3) tick();
      chk("recheck_idle", 32'(busy), 0);
      return;
    end
    tx_rdy = 1'b1;
    recheck = 1'($urandom_range(0, 3) == 0);
    exp_gnt.push_back(w);
    tick();
    tx_rdy = 1'b0;
    recheck = 1'b0;
    rq[w] = 1'b0;
    o = 1 - w;
    n = $urandom_range(1, 6);
    for (int k = 0; k < n; k++) begin
      st[w] = (k == 0);
      en[w] = (k == n - 1);
      dat[w] = 16'($urandom);
      st[o] = 1'($urandom_range(0, 1));
      en[o] = 1'($urandom_range(0, 1));
      dat[o] = 16'($urandom);
      b.st = st[w];
      b.en = en[w];
      b.d = dat[w];
      exp_beat.push_back(b);
      tick();
    end
    st[w] = 1'b0;
    en[w] = 1'b0;
    chk("idle_after_end", 32'(busy), 0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((rq[0] || rq[1]) && guard < 10) begin
      round(0, 0, 0);
      guard++;
    end
    chk("drain_done", 32'(rq[0] | rq[1]), 0);
  endtask

  initial begin
    beat_t b;
    int w;
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0;
      ln[i] = 10'd0;
      st[i] = 1'b0;
      en[i] = 1'b0;
      dat[i] = 16'd0;
    end
    tx_rdy = 1'b0;
    recheck = 1'b0;
    ph = 9'd0;
    pd = 13'd0;
    repeat (3) @(posedge clk_125);
    #1;
    chk("rst_tx_req", 32'(tx_req), 0);
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 0);
    chk("rst_tx", {13'd0, tx_st, tx_end, tx_data}, 0);
    chk("rst_owner", 32'(owner), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tmo", 32'(tmo_err), 0);
    rstn = 1'b1;
    last = 1;
    mon_en = 1;
    tick();

    for (int r = 0; r < 40; r++)
      round(r % 3 == 1, 1, 0);
    drain();

    // Watchdog: owner never raises end
    chk("tmo_pre", 32'(tmo_err), 0);
    rq[0] = 1'b1;
    ln[0] = 10'd4;
    ph = 9'd8;
    pd = 13'd8;
    last = 0;
    tick();
    chk("tmo_owner", 32'(owner), 0);
    repeat (2) tick();
    tx_rdy = 1'b1;
    exp_gnt.push_back(0);
    tick();
    tx_rdy = 1'b0;
    rq[0] = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      st[0] = (k == 0);
      en[0] = 1'b0;
      dat[0] = 16'($urandom);
      b.st = st[0];
      b.en = (k == TMO - 1);
      b.d = dat[0];
      exp_beat.push_back(b);
      tick();
    end
    st[0] = 1'b0;
    chk("tmo_idle", 32'(busy), 0);
    chk("tmo_sticky", 32'(tmo_err), 1);
    round(0, 1, 0);
    drain();

    // Reset in the middle of a transfer
    rq[0] = 1'b1;
    rq[1] = 1'b1;
    ln[0] = 10'd4;
    ln[1] = 10'd4;
    ph = 9'h100;
    pd = 13'h1000;
    w = 1 - last;
    tick();
    chk("mid_owner", 32'(owner), 32'(w));
    tx_rdy = 1'b1;
    exp_gnt.push_back(w);
    tick();
    tx_rdy = 1'b0;
    mon_en = 0;
    st[w] = 1'b1;
    dat[w] = 16'hbeef;
    #2;
    chk("mid_busy", 32'(busy), 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_tx", {13'd0, tx_st, tx_end, tx_data}, 0);
    chk("mid_rst_ctl", {28'd0, tx_req, gnt0, gnt1, busy}, 0);
    chk("mid_rst_owner", 32'(owner), 1);
    chk("mid_rst_tmo", 32'(tmo_err), 0);
    chk("mid_gnt_q", 32'(exp_gnt.size()), 0);
    st[w] = 1'b0;
    exp_beat.delete();
    tick();
    rstn = 1'b1;
    last = 1;
    mon_en = 1;
    round(0, 0, 1);
    drain();

    repeat (3) tick();
    chk("gnt_q_empty", 32'(exp_gnt.size()), 0);
    chk("beat_q_empty", 32'(exp_beat.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
